// File: rtl/param_wb_cache.sv
// param_wb_cache: parametrised write-back, write-allocate data cache.
// One CPU port in front, word-wide backing RAM behind, 1- or 2-way sets
// with a per-set LRU bit, multi-beat line transfers on the memory side.
module param_wb_cache #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 10,
   parameter int SETS   = 16,
   parameter int WORDS  = 2,
   parameter int WAYS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LINE_W = IDX_W + OFF_W;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE, RESPOND} state_t;

   state_t state_q, state_d;

   // Latched request and transfer bookkeeping
   logic [ADDR_W-1:0] req_addr_q;
   logic              req_we_q;
   logic [DATA_W-1:0] req_wdata_q;
   logic [OFF_W-1:0]  beat_q;
   logic              victim_q;

   // Line storage; way-major, one word per (set, offset)
   logic [DATA_W-1:0] data_mem [WAYS][SETS*WORDS];
   logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
   logic [SETS-1:0]   valid_q  [WAYS];
   logic [SETS-1:0]   dirty_q  [WAYS];
   logic [SETS-1:0]   lru_q;   // per set: the way to evict next

   logic [OFF_W-1:0]  req_off;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [LINE_W-1:0] acc_line;
   logic [LINE_W-1:0] fill_line;

   logic hit, hit_way, inv_found, inv_way, victim_sel;
   logic access_en, access_way, beat_last;

   assign req_off    = req_addr_q[OFF_W-1:0];
   assign req_idx    = req_addr_q[OFF_W +: IDX_W];
   assign req_tag    = req_addr_q[ADDR_W-1 -: TAG_W];
   assign acc_line   = {req_idx, req_off};
   assign fill_line  = {req_idx, beat_q};
   assign beat_last  = (beat_q == OFF_W'(WORDS - 1));
   // A RESPOND cycle is simply a guaranteed hit on the freshly filled way
   assign access_en  = ((state_q == LOOKUP) && hit) || (state_q == RESPOND);
   assign access_way = (state_q == RESPOND) ? victim_q : hit_way;

   // Tag compare across the set and victim choice (first invalid way, else LRU)
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      hit        = 1'b0;
      hit_way    = 1'b0;
      inv_found  = 1'b0;
      inv_way    = 1'b0;
      victim_sel = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
            hit     = 1'b1;
            hit_way = 1'(w);
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][req_idx]) begin
            inv_found = 1'b1;
            inv_way   = 1'(w);
         end
      end
      if (inv_found)
         victim_sel = inv_way;
      else if (WAYS > 1)
         victim_sel = lru_q[req_idx];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and memory-side beat outputs
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         IDLE: if (cpu_req) state_d = LOOKUP;
         LOOKUP: begin
            if (hit)
               state_d = IDLE;
            else if (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
               state_d = WRITEBACK;
            else
               state_d = ALLOCATE;
         end
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_mem[victim_q][req_idx], req_idx, beat_q};
            mem_wdata = data_mem[victim_q][fill_line];
            if (mem_ack && beat_last) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, beat_q};
            if (mem_ack && beat_last) state_d = RESPOND;
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, beat counter, line status bits and CPU response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_ready   <= 1'b0;
         cpu_rdata   <= '0;
         req_addr_q  <= '0;
         req_we_q    <= 1'b0;
         req_wdata_q <= '0;
         beat_q      <= '0;
         victim_q    <= 1'b0;
         lru_q       <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
      end else begin
         cpu_ready <= 1'b0;
         if ((state_q == IDLE) && cpu_req) begin
            req_addr_q  <= cpu_addr;
            req_we_q    <= cpu_we;
            req_wdata_q <= cpu_wdata;
            beat_q      <= '0;
         end
         if ((state_q == LOOKUP) && !hit)
            victim_q <= victim_sel;
         // Counter wraps to 0 after the last beat, ready for the next phase
         if (((state_q == WRITEBACK) || (state_q == ALLOCATE)) && mem_ack)
            beat_q <= beat_q + OFF_W'(1);
         if ((state_q == ALLOCATE) && mem_ack && beat_last) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
         end
         // Hits and the post-fill response both mark the touched way MRU
         if (access_en) begin
            cpu_ready      <= 1'b1;
            lru_q[req_idx] <= ~access_way;
            if (req_we_q)
               dirty_q[access_way][req_idx] <= 1'b1;
            else
               cpu_rdata <= data_mem[access_way][acc_line];
         end
      end
   end

   // Data and tag arrays: line fills and write hits
   always_ff @(posedge clk) begin
      // NOTE: storage arrays carry no reset; valid bits alone decide what is live.
      if ((state_q == ALLOCATE) && mem_ack) begin
         data_mem[victim_q][fill_line] <= mem_rdata;
         if (beat_last) tag_mem[victim_q][req_idx] <= req_tag;
      end
      if (access_en && req_we_q)
         data_mem[access_way][acc_line] <= req_wdata_q;
   end

endmodule

// File: tb/tb_param_wb_cache.sv
// tb_param_wb_cache: checks param_wb_cache against a flat-memory view of the
// address space plus a per-set recency list that predicts hits, evictions and
// the exact memory beat sequence. A second WAYS=1 instance shows direct-mapped
// thrashing.
module tb_param_wb_cache;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 10;
   localparam int SETS   = 16;
   localparam int WORDS  = 2;
   localparam int WAYS   = 2;
   localparam int NWORD  = 1 << ADDR_W;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              mem_req, mem_we, mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   logic              w1_req = 1'b0;
   logic [ADDR_W-1:0] w1_addr = '0;
   logic [DATA_W-1:0] w1_rdata, w1_mem_wdata;
   logic              w1_ready, w1_mem_req, w1_mem_we;
   logic [ADDR_W-1:0] w1_mem_addr;

   always #5 clk = ~clk;

   param_wb_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS(WORDS), .WAYS(WAYS)) u_dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack));

   param_wb_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS(WORDS), .WAYS(1)) u_dut1 (
      .clk(clk), .rst(rst), .cpu_req(w1_req), .cpu_we(1'b0), .cpu_addr(w1_addr),
      .cpu_wdata('0), .cpu_rdata(w1_rdata), .cpu_ready(w1_ready),
      .mem_req(w1_mem_req), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
      .mem_rdata(w1_mem_addr + 10'd1), .mem_ack(w1_mem_req));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- backing memory bus model ----------------
   logic [DATA_W-1:0] backing [NWORD];
   int    ack_delay = 0;
   bit    spurious  = 1'b0;   // ack asserted while no request is pending
   int    wait_cnt  = 0;
   int    total_beats = 0;
   beat_t act_q[$];

   assign mem_ack   = mem_req ? (wait_cnt >= ack_delay) : spurious;
   assign mem_rdata = backing[mem_addr];

   always @(posedge clk) begin
      if (mem_req && mem_ack) begin
         act_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
         if (mem_we) backing[mem_addr] = mem_wdata;
         total_beats <= total_beats + 1;
         wait_cnt    <= 0;
      end else if (mem_req) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
      end
   end

   int w1_rd_beats = 0, w1_wr_beats = 0;
   always @(posedge clk) begin
      if (w1_mem_req && !w1_mem_we) w1_rd_beats <= w1_rd_beats + 1;
      if (w1_mem_req && w1_mem_we)  w1_wr_beats <= w1_wr_beats + 1;
   end

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] shadow [NWORD];           // architectural value of every word
   int                set_q [SETS][$];          // resident line numbers, MRU first
   bit                dirty_line [NWORD/WORDS];
   beat_t             exp_q[$];
   logic [DATA_W-1:0] exp_rd = '0;
   bit                cur_we = 1'b0;
   bit                in_access = 1'b0;
   int                req_cycles = 0;

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) set_q[s].delete();
      for (int i = 0; i < NWORD/WORDS; i++) dirty_line[i] = 1'b0;
      for (int a = 0; a < NWORD; a++) shadow[a] = backing[a];
   endtask

   // ---------------- per-cycle compare ----------------
   bit                prev_req = 1'b0;
   int                prev_beats = 0;
   logic [20:0]       prev_bus = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_ready) begin
            check("ready_expected", int'(in_access), 1);
            if (in_access && !cur_we) check("cpu_rdata", int'(cpu_rdata), int'(exp_rd));
         end
         if (mem_req && prev_req && (total_beats == prev_beats))
            check("mem_hold_while_waiting", int'({mem_we, mem_addr, mem_wdata}), int'(prev_bus));
         if (mem_req) req_cycles++;
      end
      prev_req   = mem_req && !rst;
      prev_beats = total_beats;
      prev_bus   = {mem_we, mem_addr, mem_wdata};
   end

   // One CPU access: predict, drive, then compare timing and beat sequence
   task automatic access(input bit we, input int addr, input int wdata, output int rdata, output int lat);
      int la, s, pos, v, req0, exp_lat;
      bit got;
      la  = addr / WORDS;
      s   = la % SETS;
      pos = -1;
      exp_q.delete();
      for (int i = 0; i < set_q[s].size(); i++) if (set_q[s][i] == la) pos = i;
      if (pos >= 0) begin
         set_q[s].delete(pos);
      end else begin
         if (set_q[s].size() == WAYS) begin
            v = set_q[s].pop_back();
            if (dirty_line[v]) begin
               for (int b = 0; b < WORDS; b++)
                  exp_q.push_back('{1'b1, 10'(v*WORDS + b), shadow[v*WORDS + b]});
               dirty_line[v] = 1'b0;
            end
         end
         for (int b = 0; b < WORDS; b++)
            exp_q.push_back('{1'b0, 10'(la*WORDS + b), shadow[la*WORDS + b]});
      end
      set_q[s].push_front(la);
      if (we) begin
         shadow[addr]   = 10'(wdata);
         dirty_line[la] = 1'b1;
      end
      exp_rd  = shadow[addr];
      cur_we  = we;
      exp_lat = (pos >= 0) ? 2 : 3 + exp_q.size() * (ack_delay + 1);

      act_q.delete();
      req0 = req_cycles;
      @(negedge clk);
      in_access = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = 10'(addr);
      cpu_wdata = 10'(wdata);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         got = cpu_ready;
      end
      cpu_req = 1'b0;
      rdata   = int'(cpu_rdata);
      check("ready_seen", int'(got), 1);
      check("latency", lat, exp_lat);
      check("mem_req_cycles", req_cycles - req0, exp_q.size() * (ack_delay + 1));
      check("beat_count", act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         check("beat_we_addr_data", int'(act_q[i]), int'(exp_q[i]));
      @(negedge clk);
      check("ready_single_pulse", int'(cpu_ready), 0);
      in_access = 1'b0;
   endtask

   task automatic access1(input int addr);
      int b0, n;
      bit got;
      b0 = w1_rd_beats;
      @(negedge clk);
      w1_req  = 1'b1;
      w1_addr = 10'(addr);
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         got = w1_ready;
      end
      w1_req = 1'b0;
      check("w1_ready_seen", int'(got), 1);
      check("w1_rdata", int'(w1_rdata), (addr + 1) % NWORD);
      check("w1_refill_beats", w1_rd_beats - b0, WORDS);
      @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int rd, lat, n, a;
      for (int i = 0; i < NWORD; i++) backing[i] = 10'(i + 1);
      model_reset();

      // Reset values
      #3;
      check("rst_cpu_ready", int'(cpu_ready), 0);
      check("rst_cpu_rdata", int'(cpu_rdata), 0);
      check("rst_mem_req", int'(mem_req), 0);
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_mem_wdata", int'(mem_wdata), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Cold read, then hit in the same line
      access(1'b0, 50, 0, rd, lat);
      check("pin_read50", rd, 51);
      check("pin_read50_lat", lat, 5);
      access(1'b0, 51, 0, rd, lat);
      check("pin_read51_hit", rd, 52);
      check("pin_read51_lat", lat, 2);

      // Write-allocate, then read back
      access(1'b1, 84, 300, rd, lat);
      access(1'b0, 84, 0, rd, lat);
      check("pin_read84", rd, 300);

      // Fill second way of set 10, then evict the dirty LRU line
      access(1'b0, 116, 0, rd, lat);
      access(1'b0, 148, 0, rd, lat);
      check("pin_read148", rd, 149);
      check("pin_evict_beats", act_q.size(), 4);
      if (act_q.size() == 4) begin
         check("pin_wb0", int'(act_q[0]), int'(beat_t'{1'b1, 10'd84, 10'd300}));
         check("pin_wb1", int'(act_q[1]), int'(beat_t'{1'b1, 10'd85, 10'd86}));
         check("pin_rd0", int'(act_q[2]), int'(beat_t'{1'b0, 10'd148, 10'd149}));
      end
      check("pin_backing84", int'(backing[84]), 300);
      access(1'b0, 116, 0, rd, lat);
      check("pin_read116_hit_lat", lat, 2);

      // Slow memory: three wait cycles per beat
      ack_delay = 3;
      access(1'b0, 200, 0, rd, lat);
      check("pin_read200", rd, 201);
      check("pin_read200_lat", lat, 11);
      ack_delay = 0;

      // Dirty line that the reset below must discard
      access(1'b1, 60, 777, rd, lat);

      // Reset during beat 1 of a fill
      ack_delay = 2;
      act_q.delete();
      @(negedge clk);
      in_access = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 10'd500;
      n = 0;
      while (!(act_q.size() == 1 && mem_req) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_beat1", act_q.size(), 1);
      check("abort_beat1_addr", int'(mem_addr), 501);
      in_access = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("abort_mem_req_async", int'(mem_req), 0);
      check("abort_mem_addr", int'(mem_addr), 0);
      check("abort_no_ready", int'(cpu_ready), 0);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_ready_low", int'(cpu_ready), 0);
      check("abort_rdata_cleared", int'(cpu_rdata), 0);
      rst = 1'b0;
      model_reset();
      ack_delay = 0;

      access(1'b0, 60, 0, rd, lat);
      check("pin_dirty_lost60", rd, 61);
      access(1'b0, 50, 0, rd, lat);
      check("pin_read50_after_rst_lat", lat, 5);
      check("pin_read50_after_rst", rd, 51);

      // Randomised traffic on a few crowded sets
      for (int i = 0; i < 300; i++) begin
         ack_delay = $urandom_range(0, 2);
         spurious  = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 5) << 5) | ($urandom_range(8, 11) << 1) | $urandom_range(0, 1);
         access(1'($urandom_range(0, 1)), a, $urandom_range(0, NWORD - 1), rd, lat);
      end
      spurious = 1'b0;

      // Direct-mapped instance: alternating conflicting lines always refill
      access1(84);
      access1(116);
      access1(84);
      check("w1_no_writebacks", w1_wr_beats, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/param_wb_cache.md
Name: param_wb_cache

Overview:
- Parametrised write-back, write-allocate data cache between a single CPU port and word-wide backing RAM.
- Generalises our 16-line, 2-word direct-mapped cache in four ways:
  - configurable address/data width, set count and line length;
  - optional 2-way associativity with per-set LRU;
  - multi-beat line transfers;
  - explicit req/ready and req/ack handshakes on both sides.
- Separate unidirectional data buses replace the inout buses.

Parameters:
- ADDR_W, 10, word-address width (CPU and memory).
- DATA_W, 10, word width.
- SETS, 16, number of sets; power of 2, ≥2.
- WORDS, 2, words per line; power of 2, ≥2.
- WAYS, 2, associativity; legal values 1 or 2.
- Derived widths: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W.
- Address split: offset=addr[OFF_W-1:0], index=next IDX_W bits, tag=top bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  access request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1=write beat, 0=read beat.
- mem_addr  out  ADDR_W  beat word address.
- mem_wdata  out  DATA_W  write-beat data.
- mem_rdata  in  DATA_W  read-beat data, valid with mem_ack.
- mem_ack  in  1  beat completes on a clk edge where mem_req=mem_ack=1.

Behaviour:
- Reset:
  - clears all valid, dirty and LRU bits; state=IDLE.
  - cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Data/tag arrays are not cleared.
  - Reset mid-operation aborts immediately: mem_req drops asynchronously, no cpu_ready is issued for the in-flight access, dirty contents are lost.
- States: IDLE, LOOKUP, WRITEBACK, ALLOCATE, RESPOND.
- IDLE:
  - cpu_req sampled here only; on acceptance, latch addr/we/wdata → LOOKUP.
  - The CPU holds its request stable until cpu_ready. In the cpu_ready cycle the FSM is already in IDLE, so the CPU must drop cpu_req or the access is re-accepted.
- LOOKUP:
  - Compare the latched tag against all valid ways of the set.
  - Hit, read: register word[offset] into cpu_rdata and pulse cpu_ready next cycle.
  - Hit, write: merge cpu_wdata into word[offset], set dirty, pulse cpu_ready next cycle.
  - Hit → IDLE. Hit latency = 2 cycles from the accepting edge.
- Miss, victim selection:
  - First invalid way (way0 priority), else the LRU way; WAYS=1 always uses way0.
  - Victim valid and dirty → WRITEBACK, else → ALLOCATE.
- WRITEBACK:
  - WORDS write beats, mem_addr={victim_tag,index,beat}, beat counting 0..WORDS-1.
  - Then → ALLOCATE.
- ALLOCATE:
  - WORDS read beats, mem_addr={req_tag,index,beat}; each ack writes mem_rdata into the victim line.
  - After the last beat: tag updated, valid=1 → RESPOND.
- RESPOND: performs the access exactly as a LOOKUP hit (write miss leaves line dirty, read miss leaves it clean), pulses cpu_ready, → IDLE.
- Memory handshake:
  - mem_req/mem_we/mem_addr/mem_wdata held stable until the ack edge; next beat's values are presented the following cycle.
  - mem_req stays high between beats of one phase; mem_req=0 otherwise.
  - mem_ack with mem_req=0 is ignored.
- LRU (WAYS=2): every hit or fill marks the accessed way MRU. The LRU bit points to the other way.
- Beat counter wraps to 0 after the WORDS-1 beat.
- Simultaneous hit and dirty line: no writeback is triggered (dirty hits are served directly).

Test Plan:
- Defaults apply (idx=addr[4:1]); memory model word[a]=a+1 unless written; ack same cycle as req.
- Cold read 50 → read beats at 50,51; cpu_rdata=51. Then read 51 → hit, no mem_req, cpu_rdata=52, cpu_ready 2 cycles after acceptance.
- Write 84 ←300 → miss fills 84,85, line dirty. Read 84 → hit, cpu_rdata=300.
- LRU eviction in set 10: read 116, then read 148.
  - Expect 148 to evict LRU way holding dirty 84.
  - Required beats: mem_we=1 at 84 (300) and 85 (86), then reads at 148,149; cpu_rdata=149.
  - Subsequent read 116 → hit.
- mem_ack delayed 3 cycles per beat during a fill → mem_req/mem_addr unchanged while waiting, exactly WORDS beats, correct data returned.
- rst pulse during ALLOCATE beat 1 → mem_req=0 immediately, no cpu_ready. Afterwards read 50 misses again.
- WAYS=1 build, alternate reads 84,116,84 → every access misses and refills (no associativity).
